// File: rtl/bus_ep_pkg.sv
// Shared definitions for the bus endpoint: packet field layout, error flag bits and RX stage states.
// The optional statistics counters are enabled by defining BUS_EP_STATS_EN.
package bus_ep_pkg;

  localparam int PCKG_SZ_DEFAULT = 20;

  // The destination ID sits in the top ID_W bits of a packet; the payload fills the rest.
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_DEFAULT = 8'hFF;

  localparam int ERR_W           = 3;
  localparam int ERR_POP_EMPTY   = 2;
  localparam int ERR_RX_OVERFLOW = 1;
  localparam int ERR_MISADDR     = 0;

  typedef enum logic {
    RX_EMPTY,
    RX_HOLD
  } rx_state_e;

`ifdef BUS_EP_STATS_EN
  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value, input logic en);
    if (en && (value != {STAT_W{1'b1}})) begin
      return value + 1'b1;
    end
    return value;
  endfunction
`endif

endpackage

// File: rtl/ep_fifo.sv
// First-word-fall-through FIFO used for both the TX and RX queues of the bus endpoint.
// Writes to a full FIFO and reads from an empty one are ignored; the head never bypasses fresh write data.
module ep_fifo #(
  parameter int pckg_sz = 20,
  parameter int depth   = 8,
  localparam int AW     = $clog2(depth),
  localparam int CW     = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [pckg_sz-1:0] din,
  input  logic               rd,
  output logic [pckg_sz-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  logic [pckg_sz-1:0] mem [depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign full  = (count == CW'(depth));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Power-of-two depth lets the pointers wrap naturally; the count carries one extra bit for "full".
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_endpoint.sv
// Bus endpoint: a TX FIFO presented to the bus, an address-filtered RX FIFO feeding a host handshake stage.
// Define BUS_EP_STATS_EN to add saturating tx_cnt / rx_cnt / drop_cnt counters.
module bus_endpoint
  import bus_ep_pkg::*;
#(
  parameter int              pckg_sz   = PCKG_SZ_DEFAULT,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'd0,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [pckg_sz-1:0] rx_data,
  output logic [ERR_W-1:0]   err
`ifdef BUS_EP_STATS_EN
  ,
  output logic [STAT_W-1:0]  tx_cnt,
  output logic [STAT_W-1:0]  rx_cnt,
  output logic [STAT_W-1:0]  drop_cnt
`endif
);

  localparam int CW = $clog2(depth) + 1;

  logic               tx_full;
  logic               tx_empty;
  logic [CW-1:0]      tx_count;
  logic               tx_write;
  logic               pop_ok;
  logic               pop_empty;

  logic [pckg_sz-1:0] rx_head;
  logic               rx_full;
  logic               rx_empty;
  logic [CW-1:0]      rx_count;
  logic               rx_space_full;
  logic               rx_load;

  logic [ID_W-1:0]    dest;
  logic               addr_hit;
  logic               misaddr;
  logic               rx_accept;
  logic               rx_overflow;
  logic [ERR_W-1:0]   err_set;

  rx_state_e          rx_state;

  assign tx_ready  = !tx_full;
  assign tx_write  = tx_valid && tx_ready;
  assign pndng     = (tx_count != '0);
  assign pop_ok    = pop && !tx_empty;
  assign pop_empty = pop && tx_empty;

  ep_fifo #(
    .pckg_sz (pckg_sz),
    .depth   (depth)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_write),
    .din   (tx_data),
    .rd    (pop_ok),
    .dout  (D_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign dest     = D_push[pckg_sz-1 -: ID_W];
  assign addr_hit = (dest == id) || (dest == broadcast);
  assign misaddr  = push && !addr_hit;

  // The word parked in the output stage still counts against RX capacity, so the endpoint holds depth words total.
  assign rx_space_full = rx_full || ((rx_state == RX_HOLD) && (rx_count == CW'(depth - 1)));
  assign rx_accept     = push && addr_hit && !rx_space_full;
  assign rx_overflow   = push && addr_hit && rx_space_full;
  assign rx_load       = ((rx_state == RX_EMPTY) || rx_ready) && !rx_empty;

  ep_fifo #(
    .pckg_sz (pckg_sz),
    .depth   (depth)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_accept),
    .din   (D_push),
    .rd    (rx_load),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_EMPTY;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      case (rx_state)
        RX_EMPTY: begin
          if (!rx_empty) begin
            rx_state <= RX_HOLD;
            rx_valid <= 1'b1;
            rx_data  <= rx_head;
          end
        end
        RX_HOLD: begin
          if (rx_ready) begin
            if (!rx_empty) begin
              rx_data <= rx_head;
            end else begin
              rx_state <= RX_EMPTY;
              rx_valid <= 1'b0;
            end
          end
        end
        default: begin
          rx_state <= RX_EMPTY;
          rx_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    err_set                  = '0;
    err_set[ERR_POP_EMPTY]   = pop_empty;
    err_set[ERR_RX_OVERFLOW] = rx_overflow;
    err_set[ERR_MISADDR]     = misaddr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else begin
      err <= err | err_set;
    end
  end

`ifdef BUS_EP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      tx_cnt   <= sat_inc(tx_cnt, pop_ok);
      rx_cnt   <= sat_inc(rx_cnt, rx_accept);
      drop_cnt <= sat_inc(drop_cnt, misaddr || rx_overflow);
    end
  end
`endif

endmodule

// File: tb/tb_bus_endpoint.sv
// Self-checking bench for bus_endpoint (id=1, depth=8) using TX/RX scoreboards.
// Statistics checks run only when BUS_EP_STATS_EN is defined.
module tb_bus_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [19:0] D_pop;
  logic        pop;
  logic        push;
  logic [19:0] D_push;
  logic        tx_valid;
  logic        tx_ready;
  logic [19:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [19:0] rx_data;
  logic [2:0]  err;
`ifdef BUS_EP_STATS_EN
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [19:0] tx_q[$];
  logic [19:0] rx_q[$];

  bus_endpoint #(
    .pckg_sz   (20),
    .depth     (8),
    .id        (8'd1),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .err      (err)
`ifdef BUS_EP_STATS_EN
    ,
    .tx_cnt   (tx_cnt),
    .rx_cnt   (rx_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pop      = 1'b0;
    push     = 1'b0;
    D_push   = '0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tx_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pndng !== 1'b0) begin failures++; $display("[TB] FAIL reset_pndng got=%b want=0", pndng); end
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready got=%b want=1", tx_ready); end
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%b want=0", rx_valid); end
    checks++;
    if (D_pop !== 20'h0) begin failures++; $display("[TB] FAIL reset_D_pop got=%h want=00000", D_pop); end
    checks++;
    if (rx_data !== 20'h0) begin failures++; $display("[TB] FAIL reset_rx_data got=%h want=00000", rx_data); end
    checks++;
    if (err !== 3'b000) begin failures++; $display("[TB] FAIL reset_err got=%b want=000", err); end
  endtask

  task automatic test_tx_path();
    logic [19:0] exp;
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 20'h020A5;
    tx_q.push_back(tx_data);
    tick();
    tx_valid = 1'b0;
    checks++;
    if (pndng !== 1'b1) begin failures++; $display("[TB] FAIL tx_pndng_before_pop got=%b want=1", pndng); end
    exp = tx_q[0];
    checks++;
    if (D_pop !== exp) begin failures++; $display("[TB] FAIL tx_head got=%h want=%h", D_pop, exp); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    void'(tx_q.pop_front());
    checks++;
    if (pndng !== 1'b0) begin failures++; $display("[TB] FAIL tx_pndng_after_pop got=%b want=0", pndng); end

    // Fill to capacity with pointers already offset, so the read side wraps.
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1;
      tx_data  = 20'h01000 + 20'(i * 17);
      tx_q.push_back(tx_data);
      tick();
    end
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL tx_ready_full got=%b want=0", tx_ready); end

    for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
      exp = tx_q.pop_front();
      checks++;
      if (D_pop !== exp || pndng !== 1'b1) begin
        failures++;
        $display("[TB] FAIL tx_drain_order got=%h/%b want=%h/1", D_pop, pndng, exp);
      end
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    checks++;
    if (pndng !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tx_drained got=pndng %b ready %b want=pndng 0 ready 1", pndng, tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 20'h0AAAA;
    tx_q.push_back(tx_data);
    tick();
    tx_data = 20'h0BBBB;
    tx_q.push_back(tx_data);
    pop = 1'b1;
    exp = tx_q.pop_front();
    checks++;
    if (D_pop !== exp) begin failures++; $display("[TB] FAIL b2b_head_first got=%h want=%h", D_pop, exp); end
    tick();
    tx_valid = 1'b0;
    pop      = 1'b0;
    exp = tx_q[0];
    checks++;
    if (D_pop !== exp || pndng !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_head_second got=%h/%b want=%h/1", D_pop, pndng, exp);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    void'(tx_q.pop_front());
    checks++;
    if (pndng !== 1'b0 || err !== 3'b000) begin
      failures++;
      $display("[TB] FAIL b2b_end got=pndng %b err %b want=pndng 0 err 000", pndng, err);
    end
  endtask

  task automatic test_rx_hold();
    logic [19:0] exp;
    do_reset();
    push   = 1'b1;
    D_push = 20'h01123;
    rx_q.push_back(D_push);
    tick();
    push = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rx_no_bypass got=%b want=0", rx_valid); end
    tick();
    exp = rx_q[0];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        failures++;
        $display("[TB] FAIL rx_hold_cycle%0d got=%b/%h want=1/%h", c, rx_valid, rx_data, exp);
      end
      tick();
    end
    rx_ready = 1'b1;
    exp = rx_q.pop_front();
    checks++;
    if (rx_data !== exp) begin failures++; $display("[TB] FAIL rx_handshake_data got=%h want=%h", rx_data, exp); end
    tick();
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rx_after_consume got=%b want=0", rx_valid); end
  endtask

  task automatic test_addr_filter();
    logic [19:0] exp;
    do_reset();
    push   = 1'b1;
    D_push = 20'hFF777;
    rx_q.push_back(D_push);
    tick();
    D_push = 20'h05777;
    tick();
    push = 1'b0;
    checks++;
    if (err !== 3'b001) begin failures++; $display("[TB] FAIL filter_err got=%b want=001", err); end
    rx_ready = 1'b1;
    for (int c = 0; c < 20 && rx_q.size() > 0; c++) begin
      if (rx_valid) begin
        exp = rx_q.pop_front();
        checks++;
        if (rx_data !== exp) begin failures++; $display("[TB] FAIL filter_rx_data got=%h want=%h", rx_data, exp); end
      end
      tick();
    end
    checks++;
    if (rx_q.size() != 0) begin failures++; $display("[TB] FAIL filter_timeout got=%0d pending want=0", rx_q.size()); end
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL filter_dropped_seen got=%b want=0", rx_valid); end
    rx_ready = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [19:0] exp;
    int stored;
    int reads;
    do_reset();
    stored = 0;
    for (int i = 0; i < 9; i++) begin
      push   = 1'b1;
      D_push = 20'h01000 + 20'(i + 1);
      if (stored < 8) begin
        rx_q.push_back(D_push);
        stored++;
      end
      tick();
    end
    push = 1'b0;
    checks++;
    if (err !== 3'b010) begin failures++; $display("[TB] FAIL overflow_err got=%b want=010", err); end
    reads    = 0;
    rx_ready = 1'b1;
    for (int c = 0; c < 40 && rx_q.size() > 0; c++) begin
      if (rx_valid) begin
        exp = rx_q.pop_front();
        reads++;
        checks++;
        if (rx_data !== exp) begin failures++; $display("[TB] FAIL overflow_order got=%h want=%h", rx_data, exp); end
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      if (rx_valid) reads++;
      tick();
    end
    rx_ready = 1'b0;
    checks++;
    if (reads != 8) begin failures++; $display("[TB] FAIL overflow_read_count got=%0d want=8", reads); end
  endtask

  task automatic test_pop_empty_reset();
    do_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (err[2] !== 1'b1 || pndng !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pop_empty got=err %b pndng %b want=err 1xx pndng 0", err, pndng);
    end
    for (int i = 0; i < 3; i++) begin
      push   = 1'b1;
      D_push = 20'h01300 + 20'(i);
      tick();
    end
    push = 1'b0;
    tick();
    checks++;
    if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL rx_loaded_before_reset got=%b want=1", rx_valid); end
    // Reset lands together with fresh traffic on every input; reset must win.
    reset    = 1'b1;
    push     = 1'b1;
    D_push   = 20'h05000;
    tx_valid = 1'b1;
    tx_data  = 20'h0CCCC;
    pop      = 1'b1;
    rx_ready = 1'b1;
    tick();
    reset    = 1'b0;
    push     = 1'b0;
    tx_valid = 1'b0;
    pop      = 1'b0;
    rx_ready = 1'b0;
    checks++;
    if (err !== 3'b000 || rx_valid !== 1'b0 || pndng !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset got=err %b rx_valid %b pndng %b want=000 0 0", err, rx_valid, pndng);
    end
    tick();
    tick();
    checks++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_flushed got=rx_valid %b tx_ready %b want=0 1", rx_valid, tx_ready);
    end
  endtask

`ifdef BUS_EP_STATS_EN
  task automatic test_stats();
    logic [19:0] exp;
    logic [19:0] pkts [6];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = 20'h02500 + 20'(i);
      tx_q.push_back(tx_data);
      tick();
    end
    tx_valid = 1'b0;
    for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
      exp = tx_q.pop_front();
      checks++;
      if (D_pop !== exp) begin failures++; $display("[TB] FAIL stats_tx_order got=%h want=%h", D_pop, exp); end
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    pkts[0] = 20'h01001;
    pkts[1] = 20'h07002;
    pkts[2] = 20'hFF003;
    pkts[3] = 20'h01004;
    pkts[4] = 20'h09005;
    pkts[5] = 20'hFF006;
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push   = 1'b1;
      D_push = pkts[i];
      if (pkts[i][19:12] == 8'h01 || pkts[i][19:12] == 8'hFF) rx_q.push_back(pkts[i]);
      if (rx_valid) begin
        exp = rx_q.pop_front();
        checks++;
        if (rx_data !== exp) begin failures++; $display("[TB] FAIL stats_rx_data got=%h want=%h", rx_data, exp); end
      end
      tick();
    end
    push = 1'b0;
    for (int c = 0; c < 20 && rx_q.size() > 0; c++) begin
      if (rx_valid) begin
        exp = rx_q.pop_front();
        checks++;
        if (rx_data !== exp) begin failures++; $display("[TB] FAIL stats_rx_data got=%h want=%h", rx_data, exp); end
      end
      tick();
    end
    rx_ready = 1'b0;
    checks++;
    if (tx_cnt !== 16'd5) begin failures++; $display("[TB] FAIL stats_tx_cnt got=%0d want=5", tx_cnt); end
    checks++;
    if (rx_cnt !== 16'd4) begin failures++; $display("[TB] FAIL stats_rx_cnt got=%0d want=4", rx_cnt); end
    checks++;
    if (drop_cnt !== 16'd2) begin failures++; $display("[TB] FAIL stats_drop_cnt got=%0d want=2", drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_path();
    test_back_to_back();
    test_rx_hold();
    test_addr_filter();
    test_rx_overflow();
    test_pop_empty_reset();
`ifdef BUS_EP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
